// File: rtl/halton_pkg.sv
// Shared helpers for the Halton generator: integer powers, derived widths and the
// radical-inverse (digit-reversal) reduction.
package halton_pkg;

  function automatic logic [63:0] pow_int(input int unsigned base, input int unsigned exp);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < exp; i++) begin
      r = r * 64'(base);
    end
    return r;
  endfunction

  function automatic int unsigned calc_logbase(input int unsigned base);
    return $clog2(base);
  endfunction

  function automatic int unsigned calc_outwidth(input int unsigned base,
                                                input int unsigned n_digits);
    return $clog2(pow_int(base, n_digits));
  endfunction

  // Digit i carries weight base**(n_digits-1-i): the least significant index digit
  // becomes the most significant output digit.
  function automatic logic [63:0] rev(input logic [63:0] digits, input int unsigned base,
                                      input int unsigned n_digits, input int unsigned logbase);
    logic [63:0] acc;
    logic [63:0] mask;
    logic [63:0] dig;
    acc  = 64'd0;
    mask = (64'd1 << logbase) - 64'd1;
    for (int unsigned i = 0; i < n_digits; i++) begin
      dig = (digits >> (i * logbase)) & mask;
      acc = acc + dig * pow_int(base, n_digits - 1 - i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/halton_digit_cnt.sv
// One base-BASE digit of the sequence index: mod-BASE counter with carry out and
// clamped parallel load.
module halton_digit_cnt #(
  parameter int unsigned BASE    = 3,
  parameter int unsigned LOGBASE = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cin,
  input  logic               i_ld,
  input  logic [LOGBASE-1:0] i_ld_val,
  output logic               o_cout,
  output logic [LOGBASE-1:0] o_q
);

  localparam logic [LOGBASE-1:0] DigMax = LOGBASE'(BASE - 1);

  logic [LOGBASE-1:0] r_q;
  logic [LOGBASE-1:0] w_ld_clamped;

  // Out-of-range load values saturate so the digit is always a legal base-BASE digit.
  assign w_ld_clamped = (i_ld_val > DigMax) ? DigMax : i_ld_val;
  assign o_cout       = i_cin & (r_q == DigMax);
  assign o_q          = r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= w_ld_clamped;
    end else if (i_cin) begin
      r_q <= (r_q == DigMax) ? '0 : r_q + LOGBASE'(1);
    end
  end

endmodule

// File: rtl/halton_seq_gen.sv
// Halton radical-inverse source: a ripple chain of base-BASE digit counters with a
// registered digit-reversed output, valid flag and wrap pulse.
module halton_seq_gen
  import halton_pkg::*;
#(
  parameter int unsigned BASE     = 3,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned LOGBASE  = calc_logbase(BASE),
  parameter int unsigned OUTWIDTH = calc_outwidth(BASE, DIGITS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_ld,
  input  logic [DIGITS*LOGBASE-1:0] i_ld_digits,
  output logic [OUTWIDTH-1:0]       o_out,
  output logic                      o_out_vld,
  output logic                      o_wrap
);

  localparam int unsigned DigW = DIGITS * LOGBASE;
  localparam logic [LOGBASE-1:0] DigMax = LOGBASE'(BASE - 1);

  logic [DIGITS:0]   w_carry;
  logic [DigW-1:0]   w_digits;
  logic [DigW-1:0]   w_next_digits;
  logic [OUTWIDTH-1:0] r_out;
  logic              r_vld;
  logic              r_wrap;

  assign w_carry[0] = i_en & ~i_ld;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    halton_digit_cnt #(
      .BASE   (BASE),
      .LOGBASE(LOGBASE)
    ) u_dig (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_cin   (w_carry[g]),
      .i_ld    (i_ld),
      .i_ld_val(i_ld_digits[g*LOGBASE +: LOGBASE]),
      .o_cout  (w_carry[g+1]),
      .o_q     (w_digits[g*LOGBASE +: LOGBASE])
    );
  end

  // Mirror of the counters' next state so the reversed value can be registered on the
  // same edge that updates the digits.
  always_comb begin
    logic [LOGBASE-1:0] q;
    logic [LOGBASE-1:0] ldv;
    w_next_digits = w_digits;
    for (int i = 0; i < DIGITS; i++) begin
      q   = w_digits[i*LOGBASE +: LOGBASE];
      ldv = i_ld_digits[i*LOGBASE +: LOGBASE];
      if (i_ld) begin
        w_next_digits[i*LOGBASE +: LOGBASE] = (ldv > DigMax) ? DigMax : ldv;
      end else if (w_carry[i]) begin
        w_next_digits[i*LOGBASE +: LOGBASE] = (q == DigMax) ? '0 : q + LOGBASE'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_vld  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_vld  <= i_en | i_ld;
      r_wrap <= w_carry[DIGITS];
      if (i_en | i_ld) begin
        r_out <= OUTWIDTH'(rev(64'(w_next_digits), BASE, DIGITS, LOGBASE));
      end
    end
  end

  assign o_out     = r_out;
  assign o_out_vld = r_vld;
  assign o_wrap    = r_wrap;

endmodule
